decryption_demux: RTL and testbench
===================================

# decryption_demux

Upstream routing stage for the decryption engines. It accepts a character stream terminated by `START_DECRYPTION_TOKEN` and forwards each character, with a fixed one-cycle latency, to the engine chosen by `select_i`: Caesar, scytale or zigzag. It holds `busy_o` high from the token until the chosen engine has finished its output burst. It also guards the engines' `MAX_NOF_CHARS` buffers against overflow.

## Interface
- `D_WIDTH`, 8, character width
- `MAX_NOF_CHARS`, 50, maximum payload characters per message, token excluded
- `START_DECRYPTION_TOKEN`, 8'hFA, end-of-payload / start-decryption marker
- `clk`  in  1  clock, all logic on posedge
- `rst_n`  in  1  one clock; reset is synchronous and active-high (port keeps the codebase name; asserted = 1)
- `data_i`  in  D_WIDTH  input character
- `valid_i`  in  1  `data_i` qualifier
- `select_i`  in  2  target: 0 caesar, 1 scytale, 2 zigzag, 3 reserved
- `busy_caesar_i`, `busy_scytale_i`, `busy_zigzag_i`  in  1 each  engine busy flags
- `data_caesar_o`, `data_scytale_o`, `data_zigzag_o`  out  D_WIDTH each  forwarded character
- `valid_caesar_o`, `valid_scytale_o`, `valid_zigzag_o`  out  1 each  forward strobe
- `busy_o`  out  1  upstream must not present `valid_i` while high
- `err_o`  out  1  single-cycle error pulse

## Operation
- Registers:
  - state: IDLE, COLLECT, DISCARD, WAIT_DONE
  - `sel_q` (2b), `cnt` (6b, saturating), `seen_busy`, `guard` (3b)
- IDLE:
  - On `valid_i` with a non-token character: latch `sel_q` from `select_i`, forward the character, set `cnt`=1, go to COLLECT.
  - On `valid_i` with the token: this is an empty message. Drop it, pulse `err_o`, stay in IDLE.
- COLLECT:
  - Each non-token character is forwarded and increments `cnt`.
  - The token is forwarded; go to WAIT_DONE.
  - If a non-token character arrives while `cnt`==`MAX_NOF_CHARS`, do not forward that character. Instead forward a synthesized token, pulse `err_o`, and go to DISCARD.
- DISCARD:
  - Characters are dropped.
  - The real token ends the state and moves to WAIT_DONE; the token is not forwarded.
- WAIT_DONE:
  - `seen_busy` sets when the selected engine's busy is 1.
  - Go to IDLE on the first cycle where `seen_busy`=1 and the engine's busy is 0.
  - If the engine's busy has not been seen within 4 cycles of entry (`guard`), go to IDLE and pulse `err_o`.
- `sel_q`=3 (reserved): nothing is forwarded and all valid outputs stay 0. On the token, pulse `err_o` and return to IDLE. No WAIT_DONE phase.
- Forwarding targets only the engine selected by `sel_q`. The other two data/valid pairs stay 0.
- `select_i` is sampled only at the first character of a message. Later changes are ignored.
- A character with value 0 is treated as an ordinary payload character.

## Timing
- Reset: every output is 0; state=IDLE; `cnt`=0; `seen_busy`=0.
- Reset mid-message returns to IDLE in the same cycle. Nothing is forwarded afterwards.
- Latency: `data_x_o`/`valid_x_o` are registered and appear exactly one cycle after the accepted `valid_i`.
- `valid_x_o` is a 1-cycle strobe per character. `data_x_o` returns to 0 when `valid_x_o`=0.
- `busy_o`:
  - Registered; 1 from the cycle after the token (or overflow) is accepted, through the last WAIT_DONE cycle.
  - Also 1 in DISCARD.
  - 0 in IDLE and COLLECT.
- `valid_i` while `busy_o`=1 and state≠DISCARD: the character is ignored and `err_o` pulses. The state does not change.
- `err_o` pulses on the cycle after the offending input.
- When overflow and guard events coincide, a single pulse is produced.

## Structure
- Shared package `decryption_pkg`:
  - select encodings SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2, SEL_RSVD=3
  - the state enum
  - the default token constant
- One sub-module, `demux_route`: a combinational 1-to-3 data/valid fan-out driven by `sel_q`, placed before the output registers.
- The FSM and counters stay in the top module.

## Test plan
- Scytale message: `select_i`=1, chars 0x41..0x46 then 0xFA, scytale busy held 1 for 7 cycles after the token → six 1-cycle-delayed strobes on the scytale outputs, then 0xFA. `busy_o` is 1 until the cycle busy falls; Caesar/zigzag outputs stay 0.
- Overflow: 51 non-token chars to Caesar → 50 forwarded, then synthesized 0xFA, then `err_o` pulse. `busy_o` is 1 through DISCARD until the real token, then WAIT_DONE.
- Empty and reserved: 0xFA in IDLE → `err_o` pulse, no strobes. `select_i`=3 with 3 chars plus the token → no strobes, one `err_o`, back in IDLE.
- Protocol violation and guard: `valid_i` pulsed during WAIT_DONE → `err_o`, character ignored. Engine busy never rises → IDLE plus an `err_o` pulse 4 cycles after the token.
- Reset mid-message: `rst_n`=1 after 3 zigzag chars → all outputs 0 next cycle. A following Caesar message routes normally with `cnt` restarting at 1.

Source files
------------

// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption front end: engine select codes,
// the routing FSM state encoding and the default start-decryption token.
package decryption_pkg;

  localparam logic [1:0] SEL_CAESAR  = 2'd0;
  localparam logic [1:0] SEL_SCYTALE = 2'd1;
  localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  localparam logic [7:0] DEFAULT_TOKEN = 8'hFA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISCARD,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/demux_route.sv
// Combinational 1-to-3 fan-out of a data/valid pair onto the engine selected by sel.
// Data is zeroed on every lane that is not carrying a valid character.
module demux_route
  import decryption_pkg::*;
#(
  parameter int D_WIDTH = 8
) (
  input  logic [1:0]         sel,
  input  logic [D_WIDTH-1:0] data,
  input  logic               valid,
  output logic [D_WIDTH-1:0] data_caesar,
  output logic [D_WIDTH-1:0] data_scytale,
  output logic [D_WIDTH-1:0] data_zigzag,
  output logic               valid_caesar,
  output logic               valid_scytale,
  output logic               valid_zigzag
);

  always_comb begin
    data_caesar   = '0;
    data_scytale  = '0;
    data_zigzag   = '0;
    valid_caesar  = 1'b0;
    valid_scytale = 1'b0;
    valid_zigzag  = 1'b0;
    if (valid) begin
      case (sel)
        SEL_CAESAR: begin
          data_caesar  = data;
          valid_caesar = 1'b1;
        end
        SEL_SCYTALE: begin
          data_scytale  = data;
          valid_scytale = 1'b1;
        end
        SEL_ZIGZAG: begin
          data_zigzag  = data;
          valid_zigzag = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decryption_demux.sv
// Routes a token-terminated character stream to one decryption engine, tracks the
// engine's busy burst and guards the engine buffers against overflow.
//
// state        | meaning
// ST_IDLE      | waiting for the first character of a message
// ST_COLLECT   | forwarding payload characters to the engine latched in sel_q
// ST_DISCARD   | overflow seen, dropping characters until the real token
// ST_WAIT_DONE | waiting for the selected engine's busy burst to finish
module decryption_demux
  import decryption_pkg::*;
#(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEFAULT_TOKEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select_i,
  input  logic               busy_caesar_i,
  input  logic               busy_scytale_i,
  input  logic               busy_zigzag_i,
  output logic [D_WIDTH-1:0] data_caesar_o,
  output logic [D_WIDTH-1:0] data_scytale_o,
  output logic [D_WIDTH-1:0] data_zigzag_o,
  output logic               valid_caesar_o,
  output logic               valid_scytale_o,
  output logic               valid_zigzag_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [5:0] CNT_MAX = 6'(MAX_NOF_CHARS);

  state_t     state;
  logic [1:0] sel_q;
  logic [5:0] cnt;
  logic       seen_busy;
  logic [2:0] guard;

  logic               is_token;
  logic               overflow;
  logic               eng_busy;
  logic [1:0]         route_sel;
  logic               fwd_valid;
  logic [D_WIDTH-1:0] fwd_data;

  logic [D_WIDTH-1:0] rt_data_caesar, rt_data_scytale, rt_data_zigzag;
  logic               rt_valid_caesar, rt_valid_scytale, rt_valid_zigzag;

  assign is_token = (data_i == START_DECRYPTION_TOKEN);
  assign overflow = (cnt == CNT_MAX);

  always_comb begin
    case (sel_q)
      SEL_CAESAR:  eng_busy = busy_caesar_i;
      SEL_SCYTALE: eng_busy = busy_scytale_i;
      SEL_ZIGZAG:  eng_busy = busy_zigzag_i;
      default:     eng_busy = 1'b0;
    endcase
  end

  // The first character routes on select_i directly since sel_q is only latched on it.
  always_comb begin
    route_sel = sel_q;
    fwd_valid = 1'b0;
    fwd_data  = '0;
    case (state)
      ST_IDLE: begin
        route_sel = select_i;
        if (valid_i && !is_token) begin
          fwd_valid = 1'b1;
          fwd_data  = data_i;
        end
      end
      ST_COLLECT: begin
        if (valid_i) begin
          fwd_valid = 1'b1;
          fwd_data  = (is_token || overflow) ? START_DECRYPTION_TOKEN : data_i;
        end
      end
      default: ;
    endcase
  end

  demux_route #(.D_WIDTH(D_WIDTH)) u_route (
    .sel           (route_sel),
    .data          (fwd_data),
    .valid         (fwd_valid),
    .data_caesar   (rt_data_caesar),
    .data_scytale  (rt_data_scytale),
    .data_zigzag   (rt_data_zigzag),
    .valid_caesar  (rt_valid_caesar),
    .valid_scytale (rt_valid_scytale),
    .valid_zigzag  (rt_valid_zigzag)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state           <= ST_IDLE;
      sel_q           <= SEL_CAESAR;
      cnt             <= '0;
      seen_busy       <= 1'b0;
      guard           <= '0;
      data_caesar_o   <= '0;
      data_scytale_o  <= '0;
      data_zigzag_o   <= '0;
      valid_caesar_o  <= 1'b0;
      valid_scytale_o <= 1'b0;
      valid_zigzag_o  <= 1'b0;
      busy_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      data_caesar_o   <= rt_data_caesar;
      data_scytale_o  <= rt_data_scytale;
      data_zigzag_o   <= rt_data_zigzag;
      valid_caesar_o  <= rt_valid_caesar;
      valid_scytale_o <= rt_valid_scytale;
      valid_zigzag_o  <= rt_valid_zigzag;
      err_o           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (is_token) begin
              err_o <= 1'b1;
            end else begin
              sel_q <= select_i;
              cnt   <= 6'd1;
              state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (valid_i) begin
            if (is_token) begin
              if (sel_q == SEL_RSVD) begin
                err_o <= 1'b1;
                state <= ST_IDLE;
              end else begin
                seen_busy <= 1'b0;
                guard     <= '0;
                busy_o    <= 1'b1;
                state     <= ST_WAIT_DONE;
              end
            end else if (overflow) begin
              err_o  <= 1'b1;
              busy_o <= 1'b1;
              state  <= ST_DISCARD;
            end else if (cnt != 6'h3F) begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        ST_DISCARD: begin
          if (valid_i && is_token) begin
            if (sel_q == SEL_RSVD) begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              seen_busy <= 1'b0;
              guard     <= '0;
              state     <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (valid_i) begin
            err_o <= 1'b1;
          end
          if (seen_busy && !eng_busy) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (eng_busy) begin
            seen_busy <= 1'b1;
          end else if (!seen_busy) begin
            // Engine never started its burst: give up after four sampled cycles.
            if (guard == 3'd3) begin
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              guard <= guard + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decryption_demux.sv
// Directed bench for decryption_demux: routing, overflow, empty/reserved messages,
// protocol violation, busy guard timeout and mid-message reset.
module tb_decryption_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [1:0] select_i;
  logic       busy_caesar_i, busy_scytale_i, busy_zigzag_i;
  logic [7:0] data_caesar_o, data_scytale_o, data_zigzag_o;
  logic       valid_caesar_o, valid_scytale_o, valid_zigzag_o;
  logic       busy_o, err_o;

  int checks = 0;
  int passes = 0;

  localparam logic [7:0] TOK = 8'hFA;

  decryption_demux dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .select_i        (select_i),
    .busy_caesar_i   (busy_caesar_i),
    .busy_scytale_i  (busy_scytale_i),
    .busy_zigzag_i   (busy_zigzag_i),
    .data_caesar_o   (data_caesar_o),
    .data_scytale_o  (data_scytale_o),
    .data_zigzag_o   (data_zigzag_o),
    .valid_caesar_o  (valid_caesar_o),
    .valid_scytale_o (valid_scytale_o),
    .valid_zigzag_o  (valid_zigzag_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      passes++;
  endtask

  // Packed view of all outputs: {pad, vc, dc, vs, ds, vz, dz, busy, err}.
  function automatic logic [31:0] obs();
    return {3'b0, valid_caesar_o, data_caesar_o, valid_scytale_o, data_scytale_o,
            valid_zigzag_o, data_zigzag_o, busy_o, err_o};
  endfunction

  // tgt: 0 caesar, 1 scytale, 2 zigzag, anything else = no strobe.
  function automatic logic [31:0] ev(input int tgt, input logic [7:0] d,
                                     input logic busy, input logic err);
    logic [8:0] c, s, z;
    c = (tgt == 0) ? {1'b1, d} : 9'd0;
    s = (tgt == 1) ? {1'b1, d} : 9'd0;
    z = (tgt == 2) ? {1'b1, d} : 9'd0;
    return {3'b0, c, s, z, busy, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch);
    valid_i = 1'b1;
    data_i  = ch;
    step();
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  initial begin
    rst_n = 1'b1;
    data_i = 8'h00;
    valid_i = 1'b0;
    select_i = 2'd0;
    busy_caesar_i = 1'b0;
    busy_scytale_i = 1'b0;
    busy_zigzag_i = 1'b0;
    repeat (2) step();
    check("reset", obs(), ev(-1, 8'h00, 0, 0));
    rst_n = 1'b0;
    step();

    // Scytale message; select_i changes after the first char and must be ignored.
    select_i = 2'd1;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h41 + i));
      check("scy_char", obs(), ev(1, 8'(8'h41 + i), 0, 0));
      if (i == 0) select_i = 2'd0;
    end
    send(TOK);
    check("scy_token", obs(), ev(1, TOK, 1, 0));
    busy_scytale_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("scy_wait", obs(), ev(-1, 8'h00, 1, 0));
    end
    busy_scytale_i = 1'b0;
    step();
    check("scy_done", obs(), ev(-1, 8'h00, 0, 0));

    // Overflow on Caesar: 50 forwarded, 51st becomes a synthesized token.
    select_i = 2'd0;
    for (int i = 0; i < 50; i++) begin
      send(8'(i + 1));
      check("ovf_char", obs(), ev(0, 8'(i + 1), 0, 0));
    end
    send(8'h33);
    check("ovf_synth", obs(), ev(0, TOK, 1, 1));
    send(8'h34);
    check("ovf_discard", obs(), ev(-1, 8'h00, 1, 0));
    send(TOK);
    check("ovf_real_tok", obs(), ev(-1, 8'h00, 1, 0));
    busy_caesar_i = 1'b1;
    step();
    check("ovf_wait1", obs(), ev(-1, 8'h00, 1, 0));
    step();
    check("ovf_wait2", obs(), ev(-1, 8'h00, 1, 0));
    busy_caesar_i = 1'b0;
    step();
    check("ovf_done", obs(), ev(-1, 8'h00, 0, 0));

    // Empty message.
    send(TOK);
    check("empty_err", obs(), ev(-1, 8'h00, 0, 1));
    step();
    check("empty_after", obs(), ev(-1, 8'h00, 0, 0));

    // Reserved target.
    select_i = 2'd3;
    for (int i = 0; i < 3; i++) begin
      send(8'(8'h10 + i));
      check("rsvd_char", obs(), ev(-1, 8'h00, 0, 0));
    end
    send(TOK);
    check("rsvd_tok", obs(), ev(-1, 8'h00, 0, 1));
    step();
    check("rsvd_after", obs(), ev(-1, 8'h00, 0, 0));

    // Caesar message whose engine never goes busy, with a violation in WAIT_DONE.
    select_i = 2'd0;
    send(8'h21);
    check("guard_char", obs(), ev(0, 8'h21, 0, 0));
    send(TOK);
    check("guard_tok", obs(), ev(0, TOK, 1, 0));
    step();
    check("guard_w1", obs(), ev(-1, 8'h00, 1, 0));
    send(8'h55);
    check("viol_err", obs(), ev(-1, 8'h00, 1, 1));
    step();
    check("guard_w3", obs(), ev(-1, 8'h00, 1, 0));
    step();
    check("guard_timeout", obs(), ev(-1, 8'h00, 0, 1));
    step();
    check("guard_after", obs(), ev(-1, 8'h00, 0, 0));

    // Reset in the middle of a zigzag message; a zero char is ordinary payload.
    select_i = 2'd2;
    send(8'h00);
    check("zz_char0", obs(), ev(2, 8'h00, 0, 0));
    send(8'h5A);
    check("zz_char1", obs(), ev(2, 8'h5A, 0, 0));
    send(8'h7E);
    check("zz_char2", obs(), ev(2, 8'h7E, 0, 0));
    rst_n = 1'b1;
    valid_i = 1'b1;
    data_i = 8'h7F;
    step();
    check("rst_mid", obs(), ev(-1, 8'h00, 0, 0));
    rst_n = 1'b0;
    valid_i = 1'b0;
    data_i = 8'h00;
    step();
    check("rst_quiet", obs(), ev(-1, 8'h00, 0, 0));

    // Full 50-char Caesar message after reset: counter must have restarted.
    select_i = 2'd0;
    for (int i = 0; i < 50; i++) begin
      send(8'(8'h60 + i));
      check("post_rst_char", obs(), ev(0, 8'(8'h60 + i), 0, 0));
    end
    send(TOK);
    check("post_rst_tok", obs(), ev(0, TOK, 1, 0));
    busy_caesar_i = 1'b1;
    step();
    busy_caesar_i = 1'b0;
    step();
    check("post_rst_done", obs(), ev(-1, 8'h00, 0, 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
